// File: rtl/ram_init_pkg.sv
// Shared geometry and sequencer state encoding for the ram_init line memory
// and the blocks that read from it.
package ram_init_pkg;

    localparam int CACHE_LINE  = 128;
    localparam int CACHE_DEPTH = 32;
    localparam int ADDR_WIDTH  = $clog2(CACHE_DEPTH);

    // IDLE: nothing in flight; FETCH: RAM data arrives this cycle;
    // HOLD: response presented, waiting for the consumer.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ram_init_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus encoded winner index. The search
// starts at the priority pointer, which moves past the winner on each handshake.
module ram_init_rr_arbiter
    import ram_init_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic                en_i,
    input  logic                update_i,
    output logic [NUM_REQ-1:0]  gnt_o,
    output logic [ID_WIDTH-1:0] idx_o
);

    logic [ID_WIDTH-1:0] ptr_q, ptr_d;
    logic [ID_WIDTH-1:0] cand;
    logic                found;

    // Pick the first requester at or after the pointer, wrapping around.
    always_comb begin
        // NOTE: every output of this block gets a default before the loop, so no
        // path leaves a variable unassigned and no latch is inferred.
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ID_WIDTH'((int'(ptr_q) + i) % NUM_REQ);
            if (!found && en_i && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

    // Next search starts just after the current winner.
    always_comb begin
        ptr_d = (idx_o == ID_WIDTH'(NUM_REQ - 1)) ? '0 : idx_o + 1'b1;
    end

    // Priority pointer register; advances only when a grant is taken.
    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of block ordering.
        if (!rstn_i) begin
            ptr_q <= '0;
        end else if (update_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ram_init_arb.sv
// Read sequencer sharing the single ram_init read port among NUM_REQ clients.
// One read in flight at a time; each line returns on a registered response
// channel tagged with the owning requester ID.
module ram_init_arb
    import ram_init_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int CACHE_LINE  = ram_init_pkg::CACHE_LINE,
    parameter int CACHE_DEPTH = ram_init_pkg::CACHE_DEPTH,
    parameter int ADDR_WIDTH  = $clog2(CACHE_DEPTH),
    parameter int ID_WIDTH    = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          resp_valid_o,
    output logic [ID_WIDTH-1:0]           resp_id_o,
    output logic [CACHE_LINE-1:0]         resp_data_o,
    input  logic                          resp_ready_i,
    output logic [ADDR_WIDTH-1:0]         ram_addr_o,
    input  logic [CACHE_LINE-1:0]         ram_data_i
);

    arb_state_e              state_q, state_d;
    logic [NUM_REQ-1:0]      gnt;
    logic [ID_WIDTH-1:0]     gnt_idx;
    logic                    issue_en;
    logic                    issue;
    logic [ADDR_WIDTH-1:0]   addr_arr [NUM_REQ];
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ID_WIDTH-1:0]     id_q;
    logic [ID_WIDTH-1:0]     resp_id_q;
    logic [CACHE_LINE-1:0]   resp_data_q;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_addr_unpack
        assign addr_arr[k] = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // A new read may start when idle, or when the held response retires this
    // cycle; never while reset is asserted.
    assign issue_en = rstn_i &&
                      ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && resp_ready_i));
    assign issue    = |gnt;

    ram_init_rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .req_i    (req_valid_i),
        .en_i     (issue_en),
        .update_i (issue),
        .gnt_o    (gnt),
        .idx_o    (gnt_idx)
    );

    assign req_ready_o  = gnt;
    assign ram_addr_o   = issue ? addr_arr[gnt_idx] : addr_q;
    assign resp_valid_o = (state_q == ST_HOLD);
    assign resp_id_o    = resp_id_q;
    assign resp_data_o  = resp_data_q;

    // Next-state logic for the IDLE -> FETCH -> HOLD read sequence.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (issue) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_HOLD;
            ST_HOLD:  if (resp_ready_i) state_d = issue ? ST_FETCH : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Remember the issued address (held on the RAM port) and its owner.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            addr_q <= '0;
            id_q   <= '0;
        end else if (issue) begin
            addr_q <= ram_addr_o;
            id_q   <= gnt_idx;
        end
    end

    // Capture the RAM line and its owner when the read data arrives.
    always_ff @(posedge clk_i) begin
        // NOTE: the wide data register is reset too, so the response bus reads
        // zero after reset instead of exposing a stale line.
        if (!rstn_i) begin
            resp_id_q   <= '0;
            resp_data_q <= '0;
        end else if (state_q == ST_FETCH) begin
            resp_id_q   <= id_q;
            resp_data_q <= ram_data_i;
        end
    end

endmodule

// File: tb/tb_ram_init_arb.sv
// Self-checking bench for ram_init_arb: directed scenarios followed by random
// traffic, all checked against a transaction-level model of the arbiter.
module tb_ram_init_arb;

    localparam int NR = 4;
    localparam int AW = 5;
    localparam int LW = 128;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*AW-1:0]  req_addr = '0;
    logic [NR-1:0]     req_ready;
    logic              resp_valid;
    logic [1:0]        resp_id;
    logic [LW-1:0]     resp_data;
    logic              resp_ready = 1'b0;
    logic [AW-1:0]     ram_addr;
    logic [LW-1:0]     ram_data = '0;

    logic [LW-1:0]     mem [32];

    // Stimulus the next cycle applies.
    logic              drv_rstn = 1'b0;
    logic [NR-1:0]     drv_valid = '0;
    logic [AW-1:0]     drv_addr [NR];
    logic              drv_ready = 1'b1;

    // Values sampled at the most recent falling edge.
    logic [NR-1:0]     obs_gnt;
    logic              obs_rv;
    logic [1:0]        obs_id;
    logic [LW-1:0]     obs_data;
    logic [AW-1:0]     obs_addr;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state.
    typedef struct { int id; int addr; int rdy; } ent_t;
    ent_t q[$];
    int   m_ptr = 0;
    int   m_last = 0;
    int   cyc = 0;
    bit   rst_flag = 1'b0;

    ram_init_arb dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .req_valid_i  (req_valid),
        .req_addr_i   (req_addr),
        .req_ready_o  (req_ready),
        .resp_valid_o (resp_valid),
        .resp_id_o    (resp_id),
        .resp_data_o  (resp_data),
        .resp_ready_i (resp_ready),
        .ram_addr_o   (ram_addr),
        .ram_data_i   (ram_data)
    );

    always #5 clk = ~clk;

    // Behavioural ram_init: synchronous read, one-cycle latency.
    always @(posedge clk) ram_data <= mem[ram_addr];

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] v, input int start);
        for (int i = 0; i < NR; i++) begin
            int k;
            k = (start + i) % NR;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    // Compare this cycle against the model, then advance the model past the
    // coming rising edge.
    task automatic model_step();
        int            win;
        bit            vis;
        bit            can;
        logic [NR-1:0] exp_g;
        int            exp_addr;
        cyc++;
        if (!rstn) begin
            check("ready_in_reset", req_ready, 0);
            if (rst_flag) begin
                check("rst_resp_valid", resp_valid, 0);
                check("rst_resp_id", resp_id, 0);
                check("rst_resp_data", resp_data, 0);
                check("rst_ram_addr", ram_addr, 0);
            end
            q.delete();
            m_ptr    = 0;
            m_last   = 0;
            rst_flag = 1'b1;
            return;
        end
        rst_flag = 1'b0;
        vis   = (q.size() > 0) && (cyc >= q[0].rdy);
        can   = (q.size() == 0) || (vis && resp_ready);
        win   = can ? rr_pick(req_valid, m_ptr) : -1;
        exp_g = (win >= 0) ? NR'(1 << win) : '0;
        check("req_ready", req_ready, exp_g);
        check("resp_valid", resp_valid, vis);
        if (vis) begin
            check("resp_id", resp_id, q[0].id);
            check("resp_data", resp_data, mem[q[0].addr]);
        end
        exp_addr = (win >= 0) ? int'(drv_addr[win]) : m_last;
        check("ram_addr", ram_addr, exp_addr);
        if (vis && resp_ready) void'(q.pop_front());
        if (win >= 0) begin
            q.push_back('{win, int'(drv_addr[win]), cyc + 2});
            m_ptr  = (win + 1) % NR;
            m_last = int'(drv_addr[win]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        rstn       = drv_rstn;
        req_valid  = drv_valid;
        resp_ready = drv_ready;
        for (int k = 0; k < NR; k++) req_addr[k*AW +: AW] = drv_addr[k];
        @(negedge clk);
        obs_gnt  = req_ready;
        obs_rv   = resp_valid;
        obs_id   = resp_id;
        obs_data = resp_data;
        obs_addr = ram_addr;
        model_step();
    endtask

    task automatic do_reset(input int n);
        drv_rstn  = 1'b0;
        drv_valid = '0;
        repeat (n) cycle();
        drv_rstn = 1'b1;
    endtask

    int            got_order[$];
    logic [LW-1:0] hold_data;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k < NR; k++) drv_addr[k] = '0;

        // Reset state.
        do_reset(3);

        // Single request: requester 2, line 5.
        drv_valid   = 4'b0100;
        drv_addr[2] = 5'd5;
        drv_ready   = 1'b1;
        cycle();
        check("single_grant", obs_gnt, 4'b0100);
        drv_valid = '0;
        cycle();
        check("single_t1_valid", obs_rv, 0);
        cycle();
        check("single_t2_valid", obs_rv, 1);
        check("single_t2_id", obs_id, 2);
        check("single_t2_data", obs_data, mem[5]);

        // All requesters continuously: pointer restarts at 0 after reset.
        do_reset(2);
        drv_valid = 4'b1111;
        for (int k = 0; k < NR; k++) drv_addr[k] = AW'($urandom_range(0, 31));
        repeat (10) begin
            cycle();
            for (int k = 0; k < NR; k++)
                if (obs_gnt[k]) begin
                    got_order.push_back(k);
                    drv_addr[k] = AW'($urandom_range(0, 31));
                end
        end
        check("rr_grant_count", got_order.size(), 5);
        for (int i = 0; i < got_order.size() && i < 5; i++)
            check($sformatf("rr_order_%0d", i), got_order[i], i % NR);

        // Drain, then backpressure with requester 1 pending.
        drv_valid = '0;
        drv_ready = 1'b1;
        repeat (3) cycle();
        drv_valid   = 4'b0001;
        drv_addr[0] = 5'd7;
        cycle();
        check("bp_first_grant", obs_gnt, 4'b0001);
        drv_valid = '0;
        drv_ready = 1'b0;
        cycle();
        drv_valid   = 4'b0010;
        drv_addr[1] = 5'd9;
        cycle();
        hold_data = obs_data;
        check("bp_hold_line", hold_data, mem[7]);
        repeat (5) begin
            cycle();
            check("bp_valid_held", obs_rv, 1);
            check("bp_data_held", obs_data, hold_data);
            check("bp_no_grant", obs_gnt, 0);
        end
        drv_ready = 1'b1;
        cycle();
        check("bp_release_grant", obs_gnt, 4'b0010);
        drv_valid = '0;
        cycle();
        cycle();
        check("bp_resp_valid", obs_rv, 1);
        check("bp_resp_id", obs_id, 1);
        check("bp_resp_data", obs_data, mem[9]);

        // Wrap-around: grant 3, then with 0 and 3 valid expect 0 before 3.
        drv_valid   = 4'b1000;
        drv_addr[3] = 5'd2;
        cycle();
        check("wrap_grant3", obs_gnt, 4'b1000);
        drv_valid   = 4'b1001;
        drv_addr[0] = 5'd0;
        drv_addr[3] = 5'd31;
        cycle();
        cycle();
        check("wrap_grant0", obs_gnt, 4'b0001);
        drv_valid = 4'b1000;
        cycle();
        cycle();
        check("wrap_grant3_again", obs_gnt, 4'b1000);
        check("wrap_line0_id", obs_id, 0);
        check("wrap_line0_data", obs_data, mem[0]);
        drv_valid = '0;
        cycle();
        cycle();
        check("wrap_line31_id", obs_id, 3);
        check("wrap_line31_data", obs_data, mem[31]);

        // Reset asserted during FETCH.
        drv_valid   = 4'b0100;
        drv_addr[2] = 5'd4;
        cycle();
        check("mid_rst_grant", obs_gnt, 4'b0100);
        drv_valid = '0;
        drv_rstn  = 1'b0;
        cycle();
        check("mid_rst_no_grant", obs_gnt, 0);
        cycle();
        check("mid_rst_valid", obs_rv, 0);
        check("mid_rst_data", obs_data, 0);
        check("mid_rst_addr", obs_addr, 0);
        drv_rstn    = 1'b1;
        drv_valid   = 4'b1001;
        drv_addr[0] = 5'd3;
        drv_addr[3] = 5'd6;
        cycle();
        check("post_rst_no_stale", obs_rv, 0);
        check("post_rst_grant0", obs_gnt, 4'b0001);
        drv_valid = 4'b1000;
        cycle();
        check("post_rst_fetch_valid", obs_rv, 0);
        cycle();
        check("post_rst_resp_id", obs_id, 0);
        check("post_rst_resp_data", obs_data, mem[3]);

        // Random traffic with random backpressure; requesters obey the handshake.
        repeat (2000) begin
            drv_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NR; k++) begin
                if (obs_gnt[k] && drv_valid[k]) begin
                    drv_valid[k] = 1'($urandom_range(0, 1));
                    drv_addr[k]  = AW'($urandom_range(0, 31));
                end else if (!drv_valid[k]) begin
                    drv_valid[k] = ($urandom_range(0, 2) == 0);
                    drv_addr[k]  = AW'($urandom_range(0, 31));
                end
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
